// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for the RV32I core's load/store port. One request at a
// time is latched while ready_o is high. After LATENCY cycles a single-cycle
// rvalid_o pulse returns the load result (sign/zero-extended by funct3) or
// acknowledges a store. Stores write only the addressed byte lanes. Misaligned,
// out-of-range and illegal-funct3 accesses raise err_o and have no side effect.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     synchronous reset, active-high
//   req_i     request valid, sampled only while ready_o=1
//   we_i      1=store, 0=load
//   f3_i      funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i    byte address
//   wdata_i   store data (low byte/half used for SB/SH)
//   ready_o   high when a request can be accepted (IDLE)
//   rvalid_o  one-cycle response pulse
//   rdata_o   load result; 0 for stores and faults; held until next rvalid_o
//   err_o     access fault, meaningful while rvalid_o=1
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  f3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  req_t          req_q;
  logic          ready_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  req_t          cur;
  logic          enter_done;
  logic [32:0]   off;
  logic [AW-1:0] idx;
  logic          err_d;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [15:0]   half_sel;
  logic [31:0]   rdata_d;
  logic          mem_we;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    // In IDLE the live inputs are the request being accepted; with LATENCY=1
    // that same edge is also the commit/read edge, so decode straight from them.
    cur        = (state_q == IDLE) ? req_t'{we_i, f3_i, addr_i, wdata_i} : req_q;
    enter_done = ((state_q == IDLE) && req_i && (LATENCY == 1)) ||
                 ((state_q == WAIT) && (cnt_q <= CW'(1)));

    // 33-bit offset: an address below BASE_ADDR wraps negative and sets bit 32,
    // so a single compare against SPAN covers both range bounds.
    off = {1'b0, cur.addr} - {1'b0, BASE_ADDR};
    idx = off[AW+1:2];

    err_d = (cur.f3 inside {3'b011, 3'b110, 3'b111})
          | (cur.we && cur.f3[2])
          | ((cur.f3[1:0] == 2'b01) && cur.addr[0])
          | ((cur.f3 == 3'b010) && (cur.addr[1:0] != 2'b00))
          | (off >= SPAN);

    be    = 4'b1111;
    wlane = cur.wdata;
    unique case (cur.f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cur.addr[1:0];
        wlane = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        be    = cur.addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur.wdata[15:0]}};
      end
      default: ;
    endcase

    word     = mem[idx];
    shifted  = word >> {cur.addr[1:0], 3'b000};
    half_sel = cur.addr[1] ? word[31:16] : word[15:0];

    rdata_d = '0;
    if (!err_d && !cur.we) begin
      unique case (cur.f3)
        3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  rdata_d = {24'h0, shifted[7:0]};
        3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
        3'b101:  rdata_d = {16'h0, half_sel};
        3'b010:  rdata_d = word;
        default: rdata_d = '0;
      endcase
    end

    mem_we = enter_done && !rst_i && cur.we && !err_d;
  end

  // NOTE: the RAM array has no reset; clearing it would turn the storage into
  // a huge register bank instead of a RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            req_q   <= cur;
            cnt_q   <= CW'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (enter_done) state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (enter_done) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        err_q    <= err_d;
      end
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Bench for data_mem_responder (DEPTH=1024, BASE_ADDR=0, LATENCY=2). Each issued
// access pushes its expected response (rdata, err, response cycle) onto a
// queue; a negedge monitor pops and compares on every rvalid pulse. Scenario
// tasks also check ready/rvalid timing inline.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(32'h0000_0000),
    .LATENCY  (LAT)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .f3_i    (f3),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ready_o (ready),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failed    = 0;
  int   cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.rdata || err !== e.err || cyc != e.cyc) begin
          failed++;
          $display("FAIL %s: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   e.name, rdata, err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for ready at a negedge, drives one request for one cycle
  // and records its expected response. Returns at the negedge of cycle N+1.
  task automatic issue(input string name, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    if (ready !== 1'b1) begin
      tests_run++;
      failed++;
      $display("FAIL %s_ready_timeout: got ready=%b, required 1", name, ready);
      return;
    end
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    e.err = e_err; e.rdata = e_rd; e.cyc = cyc + LAT; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 50 && (sb.size() != 0 || ready !== 1'b1); i++) @(negedge clk);
    if (sb.size() != 0 || ready !== 1'b1) begin
      tests_run++;
      failed++;
      $display("FAIL %s_done_timeout: got pending=%0d ready=%b, required pending=0 ready=1",
               name, sb.size(), ready);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; we = 1'b1; f3 = F_W; addr = 32'h40; wdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b, required 1", ready); end
    tests_run++;
    if (rvalid !== 1'b0) begin failed++; $display("FAIL reset_rvalid: got %b, required 0", rvalid); end
    tests_run++;
    if (rdata !== 32'h0) begin failed++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    tests_run++;
    if (err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b, required 0", err); end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1) begin failed++; $display("FAIL post_reset_ready: got %b, required 1", ready); end
  endtask

  task automatic test_word();
    issue("sw_10", 1'b1, F_W, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    // Now in cycle N+1: busy through N+LAT, ready again at N+LAT+1.
    for (int k = 1; k <= LAT + 1; k++) begin
      tests_run++;
      if (ready !== (k > LAT)) begin
        failed++;
        $display("FAIL sw_ready_cycle_N+%0d: got %b, required %b", k, ready, (k > LAT));
      end
      if (k <= LAT) @(negedge clk);
    end
    issue("lw_10", 1'b0, F_W, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    wait_done("word");
  endtask

  task automatic test_byte();
    issue("sb_11",  1'b1, F_B,  32'h11, 32'h0000_00A5, 1'b0, 32'h0);
    issue("lw_10b", 1'b0, F_W,  32'h10, 32'h0, 1'b0, 32'hDEAD_A5EF);
    issue("lb_11",  1'b0, F_B,  32'h11, 32'h0, 1'b0, 32'hFFFF_FFA5);
    issue("lbu_11", 1'b0, F_BU, 32'h11, 32'h0, 1'b0, 32'h0000_00A5);
    issue("lb_10",  1'b0, F_B,  32'h10, 32'h0, 1'b0, 32'hFFFF_FFEF);
    wait_done("byte");
  endtask

  task automatic test_half();
    issue("sh_12",  1'b1, F_H,  32'h12, 32'h0000_8001, 1'b0, 32'h0);
    issue("lh_12",  1'b0, F_H,  32'h12, 32'h0, 1'b0, 32'hFFFF_8001);
    issue("lhu_12", 1'b0, F_HU, 32'h12, 32'h0, 1'b0, 32'h0000_8001);
    issue("lw_10h", 1'b0, F_W,  32'h10, 32'h0, 1'b0, 32'h8001_A5EF);
    wait_done("half");
  endtask

  task automatic test_faults();
    issue("lw_13_misaligned", 1'b0, F_W,    32'h13, 32'h0, 1'b1, 32'h0);
    issue("sh_11_misaligned", 1'b1, F_H,    32'h11, 32'h0000_BEEF, 1'b1, 32'h0);
    issue("lh_13_misaligned", 1'b0, F_H,    32'h13, 32'h0, 1'b1, 32'h0);
    issue("f3_011",           1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    issue("store_bu",         1'b1, F_BU,   32'h10, 32'h0000_0077, 1'b1, 32'h0);
    issue("lw_out_of_range",  1'b0, F_W,    32'h1000, 32'h0, 1'b1, 32'h0);
    issue("lw_wrap_range",    1'b0, F_W,    32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
    issue("lw_10_unchanged",  1'b0, F_W,    32'h10, 32'h0, 1'b0, 32'h8001_A5EF);
    issue("sw_last_word",     1'b1, F_W,    32'hFFC, 32'hCAFE_F00D, 1'b0, 32'h0);
    issue("lw_last_word",     1'b0, F_W,    32'hFFC, 32'h0, 1'b0, 32'hCAFE_F00D);
    wait_done("faults");
  endtask

  task automatic test_reset_abort();
    issue("sw_20_prior", 1'b1, F_W, 32'h20, 32'h0BAD_F00D, 1'b0, 32'h0);
    issue("lw_20_prior", 1'b0, F_W, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D);
    wait_done("abort_setup");
    issue("sw_20_aborted", 1'b1, F_W, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
    // Cycle N+1 is the WAIT cycle; its closing edge would commit the store.
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (ready !== 1'b1) begin failed++; $display("FAIL abort_ready: got %b, required 1", ready); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (rvalid !== 1'b0) begin
        failed++;
        $display("FAIL abort_rvalid_%0d: got %b, required 0", k, rvalid);
      end
      @(negedge clk);
    end
    issue("lw_20_after_abort", 1'b0, F_W, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D);
    wait_done("abort");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    issue("sw_14", 1'b1, F_W, 32'h14, 32'h1357_9BDF, 1'b0, 32'h0);
    wait_done("b2b_setup");
    n = cyc;
    req = 1'b1; we = 1'b0; f3 = F_W; addr = 32'h10; wdata = 32'h0;
    e.err = 1'b0; e.rdata = 32'h8001_A5EF; e.cyc = n + LAT; e.name = "b2b_lw_10";
    sb.push_back(e);
    // Hold a conflicting store on the bus for the whole busy period.
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b1; f3 = F_W; addr = 32'h20; wdata = 32'hFFFF_FFFF;
      tests_run++;
      if (ready !== 1'b0) begin
        failed++;
        $display("FAIL b2b_busy_ready_N+%0d: got %b, required 0", k, ready);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_ready_after_rvalid: got %b, required 1", ready);
    end
    we = 1'b0; f3 = F_W; addr = 32'h14; wdata = 32'h0;
    e.err = 1'b0; e.rdata = 32'h1357_9BDF; e.cyc = cyc + LAT; e.name = "b2b_lw_14";
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    wait_done("b2b");
    repeat (3) @(negedge clk);
    tests_run++;
    if (rdata !== 32'h1357_9BDF) begin
      failed++;
      $display("FAIL rdata_hold: got %h, required 13579bdf", rdata);
    end
    issue("lw_20_untouched", 1'b0, F_W, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D);
    issue("sw_24_ack",       1'b1, F_W, 32'h24, 32'h0000_0042, 1'b0, 32'h0);
    wait_done("b2b_tail");
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
